slot_reel_ctrl: RTL and testbench
=================================

# slot_reel_ctrl

Single-reel digit generator for the 7-segment slot machine. Cycles a BCD digit 0–9 at a fixed rate while spinning. On a stop request it decelerates through a fixed number of progressively slower steps, then settles and flags completion. Its `bcd` output feeds the per-reel BCD-to-7-segment decoder directly; one instance per reel, differentiated by `INIT_DIGIT`.

## Interface
- `CLK_DIV`, 2_500_000: clock cycles per digit advance at full speed (20 steps/s at 50 MHz); legal range ≥ 2.
- `SLOW_STEPS`, 3: number of decelerating advances after a stop request; legal range ≥ 1.
- `INIT_DIGIT`, 0: digit loaded on reset; legal range 0–9.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  start request; synchronous, already debounced, sampled every edge.
- `stop`  in  1  stop request; synchronous, already debounced, sampled every edge.
- `bcd`  out  4  current reel digit, always 0–9.
- `spinning`  out  1  high in SPIN and SLOW.
- `done`  out  1  one-cycle pulse when the reel settles.

## Operation
- States: IDLE, SPIN, SLOW, STOPPED.
- Reset (async, any time, including mid-spin):
  - state = IDLE, `bcd` = INIT_DIGIT, `spinning` = 0, `done` = 0.
  - Prescaler = 0, slow index = 0.
- IDLE or STOPPED, `start` = 1 → SPIN. Prescaler cleared, `bcd` unchanged. `stop` is ignored in these states, including when it arrives together with `start`.
- SPIN:
  - Prescaler counts 0..CLK_DIV-1.
  - The edge at which prescaler = CLK_DIV-1 advances `bcd` and clears the prescaler.
  - `start` is ignored.
  - `stop` = 1 → SLOW: prescaler cleared, slow index = 0, no advance on that edge even if the prescaler is terminal (stop wins).
- SLOW:
  - Step n (n = 0..SLOW_STEPS-1) has period CLK_DIV·(n+2) cycles, counted from the previous advance or from entry into SLOW.
  - Each period end advances `bcd`, clears the prescaler and increments n.
  - On the edge of the final advance (n = SLOW_STEPS-1): state → STOPPED, `spinning` → 0, `done` → 1.
  - `start` and `stop` are ignored.
- STOPPED: `bcd` holds. `done` returns to 0 after one cycle. Behaves as IDLE for `start`.
- Advance rule: `bcd` = (`bcd` == 9) ? 0 : `bcd` + 1. No other value ever appears on `bcd`.
- Prescaler width: $clog2(CLK_DIV·(SLOW_STEPS+1)); it never exceeds the current period minus 1.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- `start` sampled at edge E → `spinning` high after E; first advance at edge E + CLK_DIV, then every CLK_DIV edges.
- `stop` sampled at edge S in SPIN → advances at S + 2·CLK_DIV, then + 3·CLK_DIV, … up to + (SLOW_STEPS+1)·CLK_DIV cumulatively.
- Total stop-to-settle latency: CLK_DIV·Σ(n+2) for n = 0..SLOW_STEPS-1.
- Exactly SLOW_STEPS advances occur after a stop request, so the final digit is deterministic from `bcd` at S.
- `done` is high for exactly the one cycle following the final-advance edge.
- Held `start` or `stop` levels behave as repeated requests and are governed by the per-state ignore rules above.

## Test plan
- Reset: CLK_DIV=4, SLOW_STEPS=3, INIT_DIGIT=7; assert `rst` asynchronously mid-cycle → `bcd`=7, `spinning`=0, `done`=0 immediately, before the next edge.
- Spin and stop, same parameters but INIT_DIGIT=0:
  - `start` at edge 0 → `bcd` 1 at edge 4, 2 at edge 8.
  - `stop` at edge 10 → `bcd` 3 at edge 18, 4 at edge 30, 5 at edge 46.
  - `spinning` low and `done` high for exactly one cycle after edge 46.
- Wrap: INIT_DIGIT=8, `start` at edge 0 → `bcd` 9 at edge 4, 0 at edge 8; `bcd` never shows 10–15.
- Ignored inputs:
  - `stop` in IDLE → no change.
  - `start` and `stop` together in IDLE → SPIN.
  - `start` pulses during SPIN and SLOW → no timing change versus the spin-and-stop scenario.
- Stop on a terminal prescaler: `stop` at edge 4 (the same edge as the first scheduled advance) → no advance at 4; advances at 12, 24, 40; `bcd` settles at 3.
- Reset mid-SLOW, then restart: assert `rst` after edge 30 of the spin-and-stop scenario → `bcd`=INIT_DIGIT, no `done` pulse; a new `start` restarts cleanly with first advance CLK_DIV edges later.

Source files
------------

// File: rtl/slot_reel_ctrl.sv
`timescale 1ns/1ps
// slot_reel_ctrl: single-reel BCD digit generator.
// While spinning, the digit advances every CLK_DIV cycles. A stop request
// begins a deceleration of SLOW_STEPS advances with stretching periods.
// The reel then settles and pulses done for one cycle.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | after reset, digit held, waiting for start
//   SPIN    | full-speed advance every CLK_DIV cycles, waiting for stop
//   SLOW    | decelerating, step n lasts CLK_DIV*(n+2) cycles
//   STOPPED | settled, digit held, start re-launches the reel
module slot_reel_ctrl #(
    parameter int CLK_DIV    = 2_500_000,
    parameter int SLOW_STEPS = 3,
    parameter int INIT_DIGIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] bcd,
    output logic       spinning,
    output logic       done
);

    // The prescaler must hold the longest slow period minus one.
    localparam int PW = $clog2(CLK_DIV * (SLOW_STEPS + 1));
    localparam int SW = (SLOW_STEPS > 1) ? $clog2(SLOW_STEPS) : 1;

    localparam logic [PW-1:0] SPIN_TC  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] SLOW_TC0 = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] TC_STEP  = PW'(CLK_DIV);
    localparam logic [SW-1:0] LAST_IDX = SW'(SLOW_STEPS - 1);
    localparam logic [3:0]    INIT_BCD = 4'(INIT_DIGIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SPIN    = 2'd1,
        SLOW    = 2'd2,
        STOPPED = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    // Terminal count of the current slow step; grows by CLK_DIV per step,
    // which avoids a multiplier on the period compare.
    logic [PW-1:0] slow_tc, slow_tc_nxt;
    logic [SW-1:0] slow_idx, slow_idx_nxt;
    logic [3:0]    bcd_nxt;
    logic          spinning_nxt;
    logic          done_nxt;
    logic [3:0]    digit_adv;

    // Decimal wrap of the reel digit.
    always_comb begin
        digit_adv = (bcd == 4'd9) ? 4'd0 : bcd + 4'd1;
    end

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            presc    <= '0;
            slow_tc  <= SLOW_TC0;
            slow_idx <= '0;
            bcd      <= INIT_BCD;
            spinning <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            presc    <= presc_nxt;
            slow_tc  <= slow_tc_nxt;
            slow_idx <= slow_idx_nxt;
            bcd      <= bcd_nxt;
            spinning <= spinning_nxt;
            done     <= done_nxt;
        end
    end

    // Next-state, prescaler and digit-advance decisions.
    always_comb begin
        state_nxt    = state;
        presc_nxt    = presc;
        slow_tc_nxt  = slow_tc;
        slow_idx_nxt = slow_idx;
        bcd_nxt      = bcd;
        spinning_nxt = spinning;
        done_nxt     = 1'b0;

        case (state)
            IDLE, STOPPED: begin
                // stop has no meaning while the reel is at rest
                if (start) begin
                    state_nxt    = SPIN;
                    presc_nxt    = '0;
                    spinning_nxt = 1'b1;
                end
            end

            SPIN: begin
                // stop takes priority over a terminal prescaler: no advance
                if (stop) begin
                    state_nxt    = SLOW;
                    presc_nxt    = '0;
                    slow_idx_nxt = '0;
                    slow_tc_nxt  = SLOW_TC0;
                end else if (presc == SPIN_TC) begin
                    bcd_nxt   = digit_adv;
                    presc_nxt = '0;
                end else begin
                    presc_nxt = presc + 1'b1;
                end
            end

            SLOW: begin
                if (presc == slow_tc) begin
                    bcd_nxt   = digit_adv;
                    presc_nxt = '0;
                    if (slow_idx == LAST_IDX) begin
                        state_nxt    = STOPPED;
                        spinning_nxt = 1'b0;
                        done_nxt     = 1'b1;
                    end else begin
                        slow_idx_nxt = slow_idx + 1'b1;
                        slow_tc_nxt  = slow_tc + TC_STEP;
                    end
                end else begin
                    presc_nxt = presc + 1'b1;
                end
            end

            default: begin
                state_nxt    = IDLE;
                spinning_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_slot_reel_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for slot_reel_ctrl. Each spin transaction is planned from
// its start and stop edges; the resulting advance/done edges are queued and a
// free-running monitor checks what the reel actually shows.
module tb_slot_reel_ctrl;

    localparam int D    = 4;
    localparam int SS   = 3;
    localparam int INIT = 7;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic [3:0] bcd;
    logic       spinning;
    logic       done;

    slot_reel_ctrl #(
        .CLK_DIV   (D),
        .SLOW_STEPS(SS),
        .INIT_DIGIT(INIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .bcd     (bcd),
        .spinning(spinning),
        .done    (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int edge_n;
        int digit;
    } adv_t;

    adv_t adv_q[$];
    int   done_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   prev_bcd  = INIT;
    int   exp_digit = INIT;
    int   spin_from = 1;
    int   spin_to   = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic report(input string name, input int act);
        checks++;
        errors++;
        $display("FAIL %s: got %0d expected nothing (edge %0d)", name, act, cyc);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        adv_t a;
        int   de;
        forever begin
            @(posedge clk);
            #1;
            check("bcd_range", int'(bcd <= 4'd9), 1);
            check("spinning", int'(spinning), int'(cyc >= spin_from && cyc < spin_to));
            while (adv_q.size() > 0 && adv_q[0].edge_n < cyc) begin
                a = adv_q.pop_front();
                report("adv_missing_at_edge", a.edge_n);
            end
            while (done_q.size() > 0 && done_q[0] < cyc) begin
                de = done_q.pop_front();
                report("done_missing_at_edge", de);
            end
            if (int'(bcd) != prev_bcd) begin
                if (adv_q.size() == 0) begin
                    report("adv_unexpected", int'(bcd));
                end else begin
                    a = adv_q.pop_front();
                    check("adv_edge", cyc, a.edge_n);
                    check("adv_digit", int'(bcd), a.digit);
                end
                prev_bcd = int'(bcd);
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    report("done_unexpected", 1);
                end else begin
                    de = done_q.pop_front();
                    check("done_edge", cyc, de);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic rnd(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    // Asynchronous reset applied mid-cycle, outputs checked before the next edge.
    task automatic do_reset();
        #1;
        rst = 1'b1;
        #1;
        check("rst_bcd", int'(bcd), INIT);
        check("rst_spinning", int'(spinning), 0);
        check("rst_done", int'(done), 0);
        adv_q.delete();
        done_q.delete();
        prev_bcd  = INIT;
        exp_digit = INIT;
        spin_to   = cyc;
        start     = 1'b0;
        stop      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One spin: start sampled at edge e, stop sampled at e+spin_len.
    task automatic run_txn(input int spin_len, input logic both, input logic noise,
                           input int rst_off);
        int   e, s, t, d;
        adv_t a;
        e = cyc + 1;
        s = e + spin_len;
        d = exp_digit;
        for (int k = 1; e + k * D < s; k++) begin
            d = (d + 1) % 10;
            a.edge_n = e + k * D;
            a.digit  = d;
            adv_q.push_back(a);
        end
        t = s;
        for (int n = 0; n < SS; n++) begin
            t = t + D * (n + 2);
            d = (d + 1) % 10;
            a.edge_n = t;
            a.digit  = d;
            adv_q.push_back(a);
        end
        done_q.push_back(t);
        exp_digit = d;
        spin_from = e;
        spin_to   = t;
        start = 1'b1;
        stop  = both;
        while (cyc < t + 3) begin
            tick();
            if (rst_off > 0 && cyc == e + rst_off) begin
                do_reset();
                return;
            end
            start = 1'b0;
            stop  = 1'b0;
            if (cyc == s - 1) begin
                stop = 1'b1;
            end else if (cyc < s - 1) begin
                start = noise & rnd(30);
            end else if (cyc < t) begin
                start = noise & rnd(30);
                stop  = noise & rnd(30);
            end else begin
                stop = noise & rnd(30);
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        int len;
        repeat (3) @(posedge clk);
        #2;
        check("init_bcd", int'(bcd), INIT);
        check("init_spinning", int'(spinning), 0);
        rst = 1'b0;
        tick();

        // stop alone while idle must do nothing
        stop = 1'b1;
        repeat (5) tick();
        stop = 1'b0;
        tick();

        // start+stop together, stop 10 edges later, with ignored pulses throughout
        run_txn(10, 1'b1, 1'b1, 0);
        // stop on the same edge as the first scheduled advance
        run_txn(4, 1'b0, 1'b0, 0);
        // reset in SPIN
        run_txn(20, 1'b0, 1'b0, 6);
        tick();
        // reset in SLOW right after the second slow advance
        run_txn(10, 1'b0, 1'b0, 30);
        // clean restart after reset
        run_txn(7, 1'b0, 1'b0, 0);

        for (int i = 0; i < 30; i++) begin
            if (rnd(30)) len = D * $urandom_range(1, 4);
            else         len = $urandom_range(1, 3 * D + 2);
            run_txn(len, rnd(30), 1'b1, 0);
            repeat ($urandom_range(0, 5)) begin
                tick();
                stop = rnd(30);
            end
            stop = 1'b0;
        end

        repeat (5) tick();
        check("adv_q_empty", adv_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
